bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master bus arbiter. Produces the 2-bit one-hot bus_grant that drives the master-side
//  mux (01 = M1, 10 = M2, 00 = none) and per-master grant strobes. Grants are registered and
//  held for a whole tenure. Forced handover after HOLD_MAX cycles only at a transaction boundary.
// PARAMETERS
//  HOLD_MAX  16  max tenure in cycles while the other master waits; 0 = no timeout
//  CNT_W     5   tenure counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  rstn        in   1  asynchronous active-low reset
//  m1_bus_req  in   1  M1 requests bus; held high for entire tenure
//  m2_bus_req  in   1  M2 requests bus; held high for entire tenure
//  tx_busy     in   1  slave-side transaction in flight; blocks forced handover
//  bus_grant   out  2  registered one-hot grant to master mux
//  m1_grant    out  1  = bus_grant[0]
//  m2_grant    out  1  = bus_grant[1]
//  bus_busy    out  1  = |bus_grant
// BEHAVIOUR
//  Reset: state IDLE, bus_grant=2'b00, m1_grant=0, m2_grant=0, bus_busy=0, hold_cnt=0, last=M2.
//  The async reset takes effect immediately, including mid-tenure. The grant drops in the same cycle, not at the next edge.
//  FSM states: IDLE, GNT_M1, GNT_M2. bus_grant is a registered decode of the state:
//  IDLE=00, GNT_M1=01, GNT_M2=10. The value 11 is never produced.
//  IDLE:
//   - only one req high -> grant that master at the next edge (1-cycle request-to-grant latency).
//   - both reqs high -> arbitration policy (see CONFIGURATION).
//   - neither high -> stay IDLE.
//  GNT_Mx -> IDLE at the next edge when:
//   - (a) Mx req low; or
//   - (b) timeout: HOLD_MAX!=0 AND hold_cnt>=HOLD_MAX-1 AND other req high AND tx_busy low.
//  Mandatory dead cycle: every handover passes through IDLE, so the mux outputs 0 for at least one cycle.
//  Direct GNT_M1<->GNT_M2 transitions are illegal.
//  hold_cnt:
//   - cleared on entry to any GNT state and in IDLE.
//   - increments each granted cycle while the other req is high; saturates at 2**CNT_W-1.
//   - held (no increment) while the other req is low.
//  Timeout deferred by tx_busy: the grant stays with Mx until tx_busy falls, then releases at the next edge.
//  last records the most recently granted master; it is updated on entry to GNT_Mx.
//  Preempted-master rule (both modes): after release cause (b), the preempted master loses the next
//  IDLE tie-break. Mx may re-request without dropping req; it is re-granted after the other tenure.
//  Req deasserted in the same cycle as the IDLE->GNT decision: the grant is still issued, then released next cycle.
//  Both reqs low while granted: release to IDLE; no spurious grant.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: IDLE tie-break grants the master != last. Both masters requesting
//   continuously alternate tenures.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, M1 wins ties except under the preempted-master rule.
//   The last register still exists for that rule.
// TESTING
//  1. Reset: rstn=0 with m1_bus_req=1 -> bus_grant=00, bus_busy=0; rstn=1 -> next edge 01.
//  2. m1_bus_req only for 6 cycles, then drop -> bus_grant=01 from cycle 1 to cycle 6, 00 one cycle after drop.
//  3. Both reqs rise in the same cycle, fixed priority -> 01; M1 drops -> 00 for 1 cycle -> 10.
//  4. HOLD_MAX=4, M1 granted, M2 requests, tx_busy=0 -> M1 keeps grant 4 cycles with M2 waiting, then 00, then 10.
//  5. As scenario 4 but tx_busy=1 for 3 extra cycles -> release delayed until the edge after tx_busy falls; never 11.
//  6. ARB_ROUND_ROBIN_EN, both reqs held high, HOLD_MAX=2 -> grant sequence 01,01,00,10,10,00,01...;
//     rstn pulse mid-tenure -> 00 immediately.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant signal bundle between the two masters and bus_arbiter
interface bus_arbiter_if;
  logic       m1_bus_req;
  logic       m2_bus_req;
  logic       tx_busy;
  logic [1:0] bus_grant;
  logic       m1_grant;
  logic       m2_grant;
  logic       bus_busy;

  modport master (
    output m1_bus_req, m2_bus_req, tx_busy,
    input  bus_grant, m1_grant, m2_grant, bus_busy
  );

  modport slave (
    input  m1_bus_req, m2_bus_req, tx_busy,
    output bus_grant, m1_grant, m2_grant, bus_busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master arbiter with registered one-hot grant and bounded tenure
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; undefined gives fixed M1 priority.
module bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M1 = 2'd1,
    GNT_M2 = 2'd2
  } state_t;

  localparam bit              TIMEOUT_EN = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_q, last_d;        // 1 = M2 was granted most recently
  logic             preempt_q, preempt_d;  // last tenure ended by timeout, not by release
  logic [1:0]       grant_q, grant_d;
  logic             own_req;
  logic             other_req;
  logic             hold_expired;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_d       = last_q;
    preempt_d    = preempt_q;
    own_req      = 1'b0;
    other_req    = 1'b0;
    hold_expired = 1'b0;

    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (bus.m1_bus_req && bus.m2_bus_req) begin
          if (RR_EN || preempt_q) state_d = last_q ? GNT_M1 : GNT_M2;
          else                    state_d = GNT_M1;
        end else if (bus.m1_bus_req) begin
          state_d = GNT_M1;
        end else if (bus.m2_bus_req) begin
          state_d = GNT_M2;
        end
      end
      GNT_M1, GNT_M2: begin
        own_req      = (state_q == GNT_M1) ? bus.m1_bus_req : bus.m2_bus_req;
        other_req    = (state_q == GNT_M1) ? bus.m2_bus_req : bus.m1_bus_req;
        hold_expired = TIMEOUT_EN && (hold_cnt_q >= CNT_LIMIT) && other_req && !bus.tx_busy;
        if (!own_req || hold_expired) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          preempt_d  = hold_expired && own_req;
        end else if (other_req && (hold_cnt_q != CNT_MAX)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase

    if ((state_q == IDLE) && (state_d != IDLE)) begin
      last_d    = (state_d == GNT_M2);
      preempt_d = 1'b0;
    end

    grant_d = {state_d == GNT_M2, state_d == GNT_M1};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_q     <= 1'b1;
      preempt_q  <= 1'b0;
      grant_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      preempt_q  <= preempt_d;
      grant_q    <= grant_d;
    end
  end

  assign bus.bus_grant = grant_q;
  assign bus.m1_grant  = grant_q[0];
  assign bus.m2_grant  = grant_q[1];
  assign bus.bus_busy  = |grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed bench for bus_arbiter (HOLD_MAX=4 and HOLD_MAX=2 instances)
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int SAT = 31;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic r1 = 1'b0, r2 = 1'b0, tx = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  bus_arbiter_if ia ();
  bus_arbiter_if ib ();

  assign ia.m1_bus_req = r1;
  assign ia.m2_bus_req = r2;
  assign ia.tx_busy    = tx;
  assign ib.m1_bus_req = r1;
  assign ib.m2_bus_req = r2;
  assign ib.tx_busy    = tx;

  bus_arbiter #(.HOLD_MAX(4), .CNT_W(5)) dut4 (.clk(clk), .rstn(rstn), .bus(ia.slave));
  bus_arbiter #(.HOLD_MAX(2), .CNT_W(5)) dut2 (.clk(clk), .rstn(rstn), .bus(ib.slave));

  always #5 clk = ~clk;

  wire [1:0] obs_g [2];
  wire       obs_m1 [2];
  wire       obs_m2 [2];
  wire       obs_bb [2];
  assign obs_g[0] = ia.bus_grant;  assign obs_g[1] = ib.bus_grant;
  assign obs_m1[0] = ia.m1_grant;  assign obs_m1[1] = ib.m1_grant;
  assign obs_m2[0] = ia.m2_grant;  assign obs_m2[1] = ib.m2_grant;
  assign obs_bb[0] = ia.bus_busy;  assign obs_bb[1] = ib.bus_busy;

  // Reference: owner 0/1/2, cycles the other master has waited, last owner, preempted flag
  int hm     [2] = '{4, 2};
  int m_own  [2];
  int m_wait [2];
  int m_last [2];
  int m_pre  [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_wait[k] = 0; m_last[k] = 2; m_pre[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, bit a, bit b, bit t);
    int w;
    bit mine, other, expire;
    w = 0;
    if (m_own[k] == 0) begin
      if (a && b)  w = (RR || m_pre[k] != 0) ? ((m_last[k] == 1) ? 2 : 1) : 1;
      else if (a)  w = 1;
      else if (b)  w = 2;
      if (w != 0) begin
        m_own[k] = w; m_last[k] = w; m_wait[k] = 0; m_pre[k] = 0;
      end
    end else begin
      mine   = (m_own[k] == 1) ? a : b;
      other  = (m_own[k] == 1) ? b : a;
      expire = (hm[k] != 0) && (m_wait[k] >= hm[k] - 1) && other && !t;
      if (!mine || expire) begin
        m_pre[k] = (expire && mine) ? 1 : 0;
        m_own[k] = 0;
        m_wait[k] = 0;
      end else if (other) begin
        m_wait[k] = (m_wait[k] + 1 > SAT) ? SAT : m_wait[k] + 1;
      end
    end
  endfunction

  function automatic logic [1:0] mgrant(int k);
    return (m_own[k] == 1) ? 2'b01 : (m_own[k] == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rstn) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k, r1, r2, tx);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; r1 = 1'b0; r2 = 1'b0; tx = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; r1 = 1'b1; r2 = 1'b0; tx = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_g[k] !== 2'b00) begin failures++; $display("FAIL reset_grant[%0d] got=%b exp=00", k, obs_g[k]); end
      checks++;
      if (obs_bb[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, obs_bb[k]); end
    end
    rstn = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_g[k] !== 2'b01) begin failures++; $display("FAIL reset_release[%0d] got=%b exp=01", k, obs_g[k]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    r1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_g[k] !== 2'b01) begin failures++; $display("FAIL single_hold[%0d] c%0d got=%b exp=01", k, c, obs_g[k]); end
      end
    end
    r1 = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_g[k] !== 2'b00) begin failures++; $display("FAIL single_drop[%0d] got=%b exp=00", k, obs_g[k]); end
    end
  endtask

  task automatic test_tie();
    logic [1:0] seq [0:3];
    seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b10; seq[3] = 2'b00;
    do_reset();
    r1 = 1'b1; r2 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      if (s == 0) r1 = 1'b0;
      if (s == 2) r2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_g[k] !== seq[s]) begin failures++; $display("FAIL tie[%0d] step%0d got=%b exp=%b", k, s, obs_g[k], seq[s]); end
      end
    end
    tick();
    checks++;
    if (obs_g[0] !== 2'b00) begin failures++; $display("FAIL tie_no_spurious got=%b exp=00", obs_g[0]); end
  endtask

  // Scenario with HOLD_MAX=4 checked against constants; dut2 against the reference
  task automatic test_timeout(input int busy_cycles);
    int total;
    logic [1:0] exp;
    do_reset();
    r1 = 1'b1;
    total = 6 + busy_cycles;
    for (int c = 1; c <= total; c++) begin
      tick();
      if (c == 1) r2 = 1'b1;
      if (c >= 4 && c < 4 + busy_cycles) tx = 1'b1;
      else tx = 1'b0;
      exp = (c <= 4 + busy_cycles) ? 2'b01 : (c == 5 + busy_cycles) ? 2'b00 : 2'b10;
      checks++;
      if (obs_g[0] !== exp) begin failures++; $display("FAIL timeout_b%0d c%0d got=%b exp=%b", busy_cycles, c, obs_g[0], exp); end
      checks++;
      if (obs_g[1] !== mgrant(1)) begin failures++; $display("FAIL timeout_model2 c%0d got=%b exp=%b", c, obs_g[1], mgrant(1)); end
      checks++;
      if (obs_g[0] === 2'b11 || obs_g[1] === 2'b11) begin failures++; $display("FAIL timeout_onehot c%0d got=%b/%b exp=not 11", c, obs_g[0], obs_g[1]); end
    end
    r1 = 1'b0; r2 = 1'b0; tx = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [0:6];
    seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b00; seq[3] = 2'b10;
    seq[4] = 2'b10; seq[5] = 2'b00; seq[6] = 2'b01;
    do_reset();
    r1 = 1'b1; r2 = 1'b1;
    for (int s = 0; s < 7; s++) begin
      tick();
      checks++;
      if (obs_g[1] !== seq[s]) begin failures++; $display("FAIL alternate step%0d got=%b exp=%b", s, obs_g[1], seq[s]); end
      checks++;
      if (obs_g[0] !== mgrant(0)) begin failures++; $display("FAIL alternate_model4 step%0d got=%b exp=%b", s, obs_g[0], mgrant(0)); end
    end
    #2 rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_g[k] !== 2'b00 || obs_bb[k] !== 1'b0) begin
        failures++; $display("FAIL async_reset[%0d] got=%b busy=%b exp=00 busy=0", k, obs_g[k], obs_bb[k]);
      end
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    r1 = 1'b0; r2 = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      if ($urandom_range(0, 7) == 0) r2 = ~r2;
      tx = ($urandom_range(0, 3) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_g[k] !== mgrant(k)) begin failures++; $display("FAIL rand_grant[%0d] cyc%0d got=%b exp=%b", k, cyc, obs_g[k], mgrant(k)); end
        checks++;
        if (obs_m1[k] !== (m_own[k] == 1) || obs_m2[k] !== (m_own[k] == 2) || obs_bb[k] !== (m_own[k] != 0)) begin
          failures++;
          $display("FAIL rand_strobes[%0d] cyc%0d got=%b%b%b exp_owner=%0d", k, cyc, obs_m1[k], obs_m2[k], obs_bb[k], m_own[k]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_tie();
    test_timeout(0);
    test_timeout(3);
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
